// File: rtl/ws2812_rx.sv
// WS2812 NRZ stream decoder: measures high-pulse widths, rebuilds 24-bit words,
// numbers them within a frame and flags the latch (long low) that ends a frame.
`timescale 1ns/1ps
module ws2812_rx #(
   parameter int BIT_THRESH   = 6,
   parameter int MIN_HIGH     = 2,
   parameter int MAX_HIGH     = 12,
   parameter int RESET_CYCLES = 600
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        din,
   output logic [23:0] rgb_data,
   output logic [7:0]  led_num,
   output logic        valid,
   output logic        frame_done,
   output logic        bit_error,
   output logic        busy
);
   localparam int HI_W = $clog2(MAX_HIGH + 2);
   localparam int LO_W = $clog2(RESET_CYCLES + 1);
   localparam logic [HI_W-1:0] HI_SAT    = HI_W'(MAX_HIGH + 1);
   localparam logic [HI_W-1:0] HI_MIN    = HI_W'(MIN_HIGH);
   localparam logic [HI_W-1:0] HI_MAX    = HI_W'(MAX_HIGH);
   localparam logic [HI_W-1:0] HI_THRESH = HI_W'(BIT_THRESH);
   localparam logic [LO_W-1:0] LO_SAT    = LO_W'(RESET_CYCLES);
   localparam logic [LO_W-1:0] LO_LAST   = LO_W'(RESET_CYCLES - 1);

   typedef enum logic {HUNT = 1'b0, RECV = 1'b1} state_t;

   logic            din_meta_reg, din_s_reg, din_d_reg;
   logic [HI_W-1:0] hi_cnt_reg;
   logic [LO_W-1:0] lo_cnt_reg;
   state_t          state_reg, state_next;
   logic [23:0]     shift_reg, shift_next;
   logic [4:0]      bit_cnt_reg, bit_cnt_next;
   logic [7:0]      word_idx_reg, word_idx_next;
   logic            word_pend_reg, word_pend_next;
   logic [23:0]     rgb_data_reg, rgb_data_next;
   logic [7:0]      led_num_reg, led_num_next;
   logic            valid_reg, valid_next;
   logic            frame_done_reg, frame_done_next;
   logic            bit_error_reg, bit_error_next;

   logic rise, fall, latch;

   assign rise  = din_s_reg & ~din_d_reg;
   assign fall  = ~din_s_reg & din_d_reg;
   // Fires on the single cycle the low counter steps onto its saturation value.
   assign latch = ~din_s_reg && (lo_cnt_reg == LO_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         din_meta_reg   <= 1'b0;
         din_s_reg      <= 1'b0;
         din_d_reg      <= 1'b0;
         hi_cnt_reg     <= '0;
         lo_cnt_reg     <= '0;
         state_reg      <= HUNT;
         shift_reg      <= '0;
         bit_cnt_reg    <= '0;
         word_idx_reg   <= '0;
         word_pend_reg  <= 1'b0;
         rgb_data_reg   <= '0;
         led_num_reg    <= '0;
         valid_reg      <= 1'b0;
         frame_done_reg <= 1'b0;
         bit_error_reg  <= 1'b0;
      end else begin
         din_meta_reg <= din;
         din_s_reg    <= din_meta_reg;
         din_d_reg    <= din_s_reg;

         if (rise)
            hi_cnt_reg <= HI_W'(1);
         else if (din_s_reg && hi_cnt_reg != HI_SAT)
            hi_cnt_reg <= hi_cnt_reg + HI_W'(1);

         if (din_s_reg)
            lo_cnt_reg <= '0;
         else if (lo_cnt_reg != LO_SAT)
            lo_cnt_reg <= lo_cnt_reg + LO_W'(1);

         state_reg      <= state_next;
         shift_reg      <= shift_next;
         bit_cnt_reg    <= bit_cnt_next;
         word_idx_reg   <= word_idx_next;
         word_pend_reg  <= word_pend_next;
         rgb_data_reg   <= rgb_data_next;
         led_num_reg    <= led_num_next;
         valid_reg      <= valid_next;
         frame_done_reg <= frame_done_next;
         bit_error_reg  <= bit_error_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      shift_next      = shift_reg;
      bit_cnt_next    = bit_cnt_reg;
      word_idx_next   = word_idx_reg;
      word_pend_next  = 1'b0;
      rgb_data_next   = rgb_data_reg;
      led_num_next    = led_num_reg;
      valid_next      = 1'b0;
      frame_done_next = 1'b0;
      bit_error_next  = 1'b0;

      // A completed word is published one cycle after its last bit lands.
      if (word_pend_reg) begin
         rgb_data_next = shift_reg;
         led_num_next  = word_idx_reg;
         valid_next    = 1'b1;
         word_idx_next = word_idx_reg + 8'd1;
      end

      case (state_reg)
         HUNT: begin
            if (latch) begin
               state_next    = RECV;
               shift_next    = '0;
               bit_cnt_next  = '0;
               word_idx_next = '0;
            end
         end
         RECV: begin
            if (fall) begin
               if (hi_cnt_reg < HI_MIN) begin
                  // glitch: nothing to do
               end else if (hi_cnt_reg > HI_MAX) begin
                  bit_error_next = 1'b1;
                  shift_next     = '0;
                  bit_cnt_next   = '0;
                  state_next     = HUNT;
               end else begin
                  shift_next = {shift_reg[22:0], (hi_cnt_reg >= HI_THRESH)};
                  if (bit_cnt_reg == 5'd23) begin
                     bit_cnt_next   = '0;
                     word_pend_next = 1'b1;
                  end else begin
                     bit_cnt_next = bit_cnt_reg + 5'd1;
                  end
               end
            end else if (latch) begin
               bit_error_next  = (bit_cnt_reg != '0);
               frame_done_next = (word_idx_reg != '0);
               shift_next      = '0;
               bit_cnt_next    = '0;
               word_idx_next   = '0;
            end
         end
         default: state_next = HUNT;
      endcase
   end

   assign rgb_data   = rgb_data_reg;
   assign led_num    = led_num_reg;
   assign valid      = valid_reg;
   assign frame_done = frame_done_reg;
   assign bit_error  = bit_error_reg;
   assign busy       = (state_reg == RECV) && (bit_cnt_reg != '0 || din_s_reg);

endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: directed protocol scenarios plus randomized frames, all
// checked cycle by cycle against a run-length model of the line.
`timescale 1ns/1ps
module tb_ws2812_rx;
   localparam int BIT_THRESH   = 6;
   localparam int MIN_HIGH     = 2;
   localparam int MAX_HIGH     = 12;
   localparam int RESET_CYCLES = 600;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        din;
   logic [23:0] rgb_data;
   logic [7:0]  led_num;
   logic        valid, frame_done, bit_error, busy;

   ws2812_rx dut (
      .clk(clk), .reset_n(reset_n), .din(din),
      .rgb_data(rgb_data), .led_num(led_num), .valid(valid),
      .frame_done(frame_done), .bit_error(bit_error), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: runs of line samples ----------------
   // Each edge consumes the din sample taken two edges earlier (synchronizer
   // depth); run lengths of high/low samples give pulse widths and latches.
   logic        h1 = 1'b0, h2 = 1'b0;
   logic        m_prev = 1'b0;
   int          m_hi = 0, m_lo = 0;
   bit          m_recv = 0;
   int          m_bits = 0, m_idx = 0;
   logic [23:0] m_word = '0;
   bit          pend = 0;
   logic [23:0] pend_data = '0;
   logic [7:0]  pend_idx = '0;
   logic [23:0] exp_rgb = '0;
   logic [7:0]  exp_led = '0;
   logic        exp_valid = 1'b0, exp_fd = 1'b0, exp_err = 1'b0, exp_busy = 1'b0;

   task automatic model_reset();
      h1 = 0; h2 = 0; m_prev = 0; m_hi = 0; m_lo = 0;
      m_recv = 0; m_bits = 0; m_idx = 0; m_word = '0; pend = 0;
      exp_rgb = '0; exp_led = '0;
      exp_valid = 0; exp_fd = 0; exp_err = 0; exp_busy = 0;
   endtask

   task automatic model_pulse(input int w);
      if (!m_recv || w < MIN_HIGH) return;
      if (w > MAX_HIGH) begin
         exp_err = 1; m_recv = 0; m_bits = 0; m_word = '0;
      end else begin
         m_word = {m_word[22:0], (w >= BIT_THRESH)};
         m_bits++;
         if (m_bits == 24) begin
            pend = 1; pend_data = m_word; pend_idx = 8'(m_idx);
            m_idx = (m_idx + 1) % 256;
            m_bits = 0;
         end
      end
   endtask

   task automatic model_latch();
      if (!m_recv) begin
         m_recv = 1;
      end else begin
         if (m_bits != 0) exp_err = 1;
         if (m_idx != 0) exp_fd = 1;
      end
      m_bits = 0; m_idx = 0;
   endtask

   task automatic model_step(input logic d);
      logic s;
      exp_valid = 0; exp_fd = 0; exp_err = 0;
      if (pend) begin
         exp_valid = 1; exp_rgb = pend_data; exp_led = pend_idx; pend = 0;
      end
      s = h2;
      if (s) begin
         m_hi = m_prev ? m_hi + 1 : 1;
         m_lo = 0;
      end else begin
         if (m_prev) begin
            model_pulse(m_hi);
            m_lo = 1;
         end else begin
            m_lo++;
         end
         if (m_lo == RESET_CYCLES) model_latch();
      end
      m_prev = s;
      exp_busy = m_recv && (m_bits != 0 || h1);
      h2 = h1; h1 = d;
   endtask

   // DUT event log used by the directed literal checks
   int          n_valid = 0, n_fd = 0, n_err = 0;
   logic [23:0] log_rgb[$];
   logic [7:0]  log_led[$];

   always @(posedge clk) begin
      if (!reset_n) model_reset();
      else model_step(din);
      #1;
      chk("rgb_data", 32'(rgb_data), 32'(exp_rgb));
      chk("led_num", 32'(led_num), 32'(exp_led));
      chk("valid", 32'(valid), 32'(exp_valid));
      chk("frame_done", 32'(frame_done), 32'(exp_fd));
      chk("bit_error", 32'(bit_error), 32'(exp_err));
      chk("busy", 32'(busy), 32'(exp_busy));
      if (valid === 1'b1) begin
         n_valid++; log_rgb.push_back(rgb_data); log_led.push_back(led_num);
      end
      if (frame_done === 1'b1) n_fd++;
      if (bit_error === 1'b1) n_err++;
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic v, input int n);
      repeat (n) begin
         @(negedge clk);
         din = v;
      end
   endtask

   task automatic latch_gap();
      drive(1'b0, RESET_CYCLES + 20);
   endtask

   // Sends the top n bits of w, T0H=4 / T1H=8, 15-cycle period; optionally a
   // glen-cycle pulse inside the low gap after bit index gpos (MSB = 0).
   task automatic send_bits(input logic [23:0] w, input int n, input int gpos, input int glen);
      logic b;
      int   lo;
      for (int i = 0; i < n; i++) begin
         b  = w[23-i];
         lo = b ? 7 : 11;
         drive(1'b1, b ? 8 : 4);
         if (i == gpos) begin
            drive(1'b0, 3);
            drive(1'b1, glen);
            drive(1'b0, lo - 3);
         end else begin
            drive(1'b0, lo);
         end
      end
   endtask

   task automatic send_word(input logic [23:0] w);
      send_bits(w, 24, -1, 0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int v0, f0, e0, q0;
      reset_n = 1'b0;
      din     = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_rgb", 32'(rgb_data), 32'h0);
      chk("reset_valid", 32'(valid), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      reset_n = 1'b1;

      // single word
      v0 = n_valid; f0 = n_fd; e0 = n_err;
      latch_gap(); send_word(24'hA5C33C); latch_gap();
      chk("t1_valid_cnt", n_valid - v0, 1);
      chk("t1_rgb", 32'(log_rgb[$]), 32'hA5C33C);
      chk("t1_led", 32'(log_led[$]), 32'h0);
      chk("t1_fd_cnt", n_fd - f0, 1);
      chk("t1_err_cnt", n_err - e0, 0);

      // multi-word frames
      f0 = n_fd; q0 = log_rgb.size();
      latch_gap();
      send_word(24'h000001); send_word(24'hFFFFFF); send_word(24'h123456);
      latch_gap(); send_word(24'hABCDEF); latch_gap();
      chk("t2_valid_cnt", log_rgb.size() - q0, 4);
      chk("t2_rgb0", 32'(log_rgb[q0]), 32'h000001);
      chk("t2_rgb1", 32'(log_rgb[q0+1]), 32'hFFFFFF);
      chk("t2_rgb2", 32'(log_rgb[q0+2]), 32'h123456);
      chk("t2_rgb3", 32'(log_rgb[q0+3]), 32'hABCDEF);
      chk("t2_led1", 32'(log_led[q0+1]), 32'h1);
      chk("t2_led2", 32'(log_led[q0+2]), 32'h2);
      chk("t2_led3", 32'(log_led[q0+3]), 32'h0);
      chk("t2_fd_cnt", n_fd - f0, 2);

      // glitch immunity, then a 2-cycle pulse decoded as an extra 0 bit
      e0 = n_err; v0 = n_valid;
      latch_gap(); send_bits(24'h0F0F0F, 24, 5, 1); latch_gap();
      chk("t3_glitch_rgb", 32'(log_rgb[$]), 32'h0F0F0F);
      chk("t3_glitch_err", n_err - e0, 0);
      send_bits(24'h0F0F0F, 24, 5, 2); latch_gap();
      chk("t3_shift_rgb", 32'(log_rgb[$]), 32'h0D8787);
      chk("t3_shift_err", n_err - e0, 1);
      chk("t3_valid_cnt", n_valid - v0, 2);

      // over-long high pulse
      v0 = n_valid; e0 = n_err; f0 = n_fd;
      latch_gap(); send_bits(24'h5A5A5A, 12, -1, 0);
      drive(1'b1, 20); drive(1'b0, 10);
      send_word(24'h55AA55); drive(1'b0, 20);
      chk("t4_no_valid", n_valid - v0, 0);
      chk("t4_err_cnt", n_err - e0, 1);
      latch_gap(); send_word(24'h3C3C3C); latch_gap();
      chk("t4_valid_cnt", n_valid - v0, 1);
      chk("t4_rgb", 32'(log_rgb[$]), 32'h3C3C3C);
      chk("t4_led", 32'(log_led[$]), 32'h0);
      chk("t4_fd_cnt", n_fd - f0, 1);

      // partial word at latch
      v0 = n_valid; e0 = n_err; f0 = n_fd;
      latch_gap(); send_bits(24'hC0FFEE, 5, -1, 0);
      chk("t5_busy_mid", 32'(busy), 32'h1);
      send_bits(24'hEE0000, 5, -1, 0);
      latch_gap();
      chk("t5_busy_after", 32'(busy), 32'h0);
      chk("t5_err_cnt", n_err - e0, 1);
      chk("t5_valid_cnt", n_valid - v0, 0);
      chk("t5_fd_cnt", n_fd - f0, 0);

      // asynchronous reset mid-word
      latch_gap(); send_word(24'h112233); drive(1'b0, 5);
      send_bits(24'h445566, 8, -1, 0);
      v0 = n_valid;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("t6_rst_rgb", 32'(rgb_data), 32'h0);
      chk("t6_rst_led", 32'(led_num), 32'h0);
      chk("t6_rst_busy", 32'(busy), 32'h0);
      chk("t6_rst_valid", 32'(valid), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      send_bits(24'h556600, 16, -1, 0); send_word(24'h778899); drive(1'b0, 20);
      chk("t6_no_valid", n_valid - v0, 0);
      latch_gap(); send_word(24'h9ABCDE); latch_gap();
      chk("t6_resume_rgb", 32'(log_rgb[$]), 32'h9ABCDE);
      chk("t6_resume_led", 32'(log_led[$]), 32'h0);

      // randomized frames with jittered timing, glitches and rare errors
      for (int f = 0; f < 20; f++) begin
         int nw;
         latch_gap();
         nw = $urandom_range(1, 3);
         for (int k = 0; k < nw; k++) begin
            logic [23:0] w;
            w = 24'($urandom());
            for (int i = 23; i >= 0; i--) begin
               int hi;
               hi = w[i] ? $urandom_range(BIT_THRESH, MAX_HIGH) : $urandom_range(MIN_HIGH, BIT_THRESH - 1);
               if ($urandom_range(0, 199) == 0) hi = $urandom_range(MAX_HIGH + 1, 20);
               drive(1'b1, hi);
               if ($urandom_range(0, 29) == 0) begin
                  drive(1'b0, 2); drive(1'b1, 1);
               end
               drive(1'b0, $urandom_range(2, 10));
            end
         end
         if ($urandom_range(0, 4) == 0) send_bits(24'($urandom()), $urandom_range(1, 23), -1, 0);
      end
      latch_gap();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
